ram_req_ctrl: RTL and testbench
===============================

# ram_req_ctrl

Request controller that sits directly upstream of the multi-width byte RAM (byte, half-word and word accesses). It accepts read and write requests over a valid/ready channel and checks alignment, size encoding and address range. Legal accesses are issued to the RAM port as single-cycle operations. Every request, legal or not, is returned on a valid/ready response channel with data and an error bit. Saturating error counters are kept per direction.

## Interface
Parameters:
- ADDR_WIDTH, 4, byte address width
- DATA_WIDTH, 8, bits per RAM location
- DEPTH, 16, number of RAM locations; must be ≤ 2**ADDR_WIDTH

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  4*DATA_WIDTH  write data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  4*DATA_WIDTH  read data, zero-extended; 0 for writes and errors
- rsp_err  out  1  request was rejected
- ram_w_en  out  1  RAM write enable
- ram_select  out  2  RAM width select
- ram_w_addr, ram_r_addr  out  ADDR_WIDTH  RAM addresses
- ram_w_data  out  4*DATA_WIDTH  RAM write data
- ram_r_data  in  4*DATA_WIDTH  RAM combinational read data
- cnt_clr  in  1  clear both error counters
- wr_err_count, rd_err_count  out  8  saturating error counts

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
- IDLE: req_ready=1. On req_valid, latch we, size, addr and wdata, then go to EXEC.
- EXEC (one cycle): compute err from the latched request.
  - err = 1 when size==11.
  - err = 1 for half with addr[0]≠0.
  - err = 1 for word with addr[1:0]≠0.
  - err = 1 when addr + nbytes > DEPTH. Evaluate in ADDR_WIDTH+3 bits, no wrap.
  - Write without err: ram_w_en=1 for exactly this cycle.
  - Read without err: capture ram_r_data masked to 8/16/32 bits into rsp_data.
  - With err: no RAM write; rsp_data=0; increment wr_err_count or rd_err_count per we.
- RESP: rsp_valid=1 and rsp_data/rsp_err held stable until rsp_ready. Return to IDLE on the cycle rsp_ready is sampled high.
- ram_select, ram_w_addr, ram_r_addr and ram_w_data are driven from the latched request in all states; they are 0 after reset.
- Counters saturate at 255.
  - cnt_clr zeroes both counters.
  - If cnt_clr and an increment occur in the same cycle, the result is 0 (clear wins).

## Timing
- Reset values: req_ready=0 during rst, then 1 in IDLE. rsp_valid=0, rsp_err=0, rsp_data=0, ram_w_en=0, both counters 0, state IDLE.
- Request accepted at edge N; EXEC during cycle N+1; RAM write commits at edge N+2; rsp_valid high from cycle N+2.
- Minimum spacing between accepted requests is 3 cycles. req_ready=0 outside IDLE, so there is no request/response overlap.
- Backpressure: while rsp_ready=0, stay in RESP indefinitely with outputs stable.
- rst asserted in any state: the next edge returns to IDLE. A pending request is dropped with no response; a write in EXEC does not occur if rst is high that cycle.
- A counter increment becomes visible on the edge ending EXEC.

## Structure
- Shared package ram_pkg holds:
  - size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
  - state enum {IDLE, EXEC, RESP}
  - function nbytes(size), returning 1/2/4
- Sub-module sat_cnt8: 8-bit saturating counter with inc and clr (clr priority). Instantiated twice.

## Test plan
- Write word 0xDEADBEEF to addr 4, then read word at addr 4. Expect rsp_data=0xDEADBEEF, rsp_err=0, and ram_w_en high exactly one cycle, two cycles after acceptance.
- Write half 0x1234 to addr 3. Expect rsp_err=1, no ram_w_en pulse, wr_err_count=1. Read word at addr 2: rsp_err=1, rd_err_count=1.
- Read word at addr 12 with DEPTH=16: rsp_err=0. Read half at addr 14 with DEPTH=16: rsp_err=0. Read word at addr 14 with DEPTH=16: rsp_err=1. Read with size=11: rsp_err=1.
- Hold rsp_ready=0 for 10 cycles after a byte read of 0xA5. Expect rsp_valid and rsp_data=0x000000A5 stable, req_ready=0, and return to IDLE on the cycle after rsp_ready=1.
- Issue 300 misaligned writes. Expect wr_err_count=255. Pulse cnt_clr on the same cycle as a further error increment: expect 0.
- Assert rst during EXEC of a legal write. Expect no ram_w_en pulse, no response, and req_ready=1 one cycle after rst deasserts.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared encodings and helpers for the RAM request controller and its bench.
package ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    // Reserved size reports 4 so the range check stays meaningful; it is rejected anyway.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_req_ctrl_if.sv
// Request/response channel between a requester (master) and the RAM request controller (slave).
interface ram_req_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [1:0]              req_size;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [4*DATA_WIDTH-1:0] req_wdata;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [4*DATA_WIDTH-1:0] rsp_data;
    logic                    rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/sat_cnt8.sv
// 8-bit saturating event counter; clear takes priority over increment.
module sat_cnt8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request controller for the multi-width byte RAM: validates each request,
// issues legal ones as single-cycle RAM operations and always returns a response.
module ram_req_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ram_req_ctrl_if.slave           bus,
    output logic                    ram_w_en,
    output logic [1:0]              ram_select,
    output logic [ADDR_WIDTH-1:0]   ram_w_addr,
    output logic [ADDR_WIDTH-1:0]   ram_r_addr,
    output logic [4*DATA_WIDTH-1:0] ram_w_data,
    input  logic [4*DATA_WIDTH-1:0] ram_r_data,
    input  logic                    cnt_clr,
    output logic [7:0]              wr_err_count,
    output logic [7:0]              rd_err_count
);

    localparam int EXT_W = ADDR_WIDTH + 3;
    localparam int RW    = 4 * DATA_WIDTH;

    typedef struct packed {
        logic                  we;
        logic [1:0]            size;
        logic [ADDR_WIDTH-1:0] addr;
        logic [RW-1:0]         wdata;
    } req_t;

    state_t           state;
    req_t             req_q;
    logic             err;
    logic             exec_err;
    logic [EXT_W-1:0] end_addr;
    logic [RW-1:0]    rd_data;

    assign bus.req_ready = (state == IDLE) && !rst;

    // The range check is widened so addr + nbytes cannot wrap back into range.
    always_comb begin
        end_addr = EXT_W'(req_q.addr) + EXT_W'(nbytes(req_q.size));
        err = (req_q.size == SZ_RSVD)
           || (req_q.size == SZ_HALF && req_q.addr[0])
           || (req_q.size == SZ_WORD && req_q.addr[1:0] != 2'b00)
           || (end_addr > EXT_W'(DEPTH));
    end

    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    always_comb begin
        rd_data = '0;
        case (req_q.size)
            SZ_BYTE: rd_data[DATA_WIDTH-1:0]   = ram_r_data[DATA_WIDTH-1:0];
            SZ_HALF: rd_data[2*DATA_WIDTH-1:0] = ram_r_data[2*DATA_WIDTH-1:0];
            SZ_WORD: rd_data                   = ram_r_data;
            default: rd_data                   = '0;
        endcase
    end

    // NOTE: combinational, so a reset raised during EXEC suppresses the write in that same cycle.
    assign ram_w_en   = (state == EXEC) && req_q.we && !err && !rst;
    assign exec_err   = (state == EXEC) && err;
    assign ram_select = req_q.size;
    assign ram_w_addr = req_q.addr;
    assign ram_r_addr = req_q.addr;
    assign ram_w_data = req_q.wdata;

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_q         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q <= '{we: bus.req_we, size: bus.req_size,
                                   addr: bus.req_addr, wdata: bus.req_wdata};
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    bus.rsp_err   <= err;
                    bus.rsp_data  <= (err || req_q.we) ? '0 : rd_data;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_cnt8 u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (exec_err && req_q.we),
        .clr   (cnt_clr),
        .count (wr_err_count)
    );

    sat_cnt8 u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (exec_err && !req_q.we),
        .clr   (cnt_clr),
        .count (rd_err_count)
    );

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl: directed vector table, corner-case sequences
// and randomized traffic scored against a byte-array reference model.
module tb_ram_req_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        cnt_clr = 1'b0;
    logic        ram_w_en;
    logic [1:0]  ram_select;
    logic [AW-1:0] ram_w_addr;
    logic [AW-1:0] ram_r_addr;
    logic [31:0] ram_w_data;
    logic [31:0] ram_r_data;
    logic [7:0]  wr_err_count;
    logic [7:0]  rd_err_count;

    int n_checks = 0;
    int n_err    = 0;

    ram_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ram_w_en     (ram_w_en),
        .ram_select   (ram_select),
        .ram_w_addr   (ram_w_addr),
        .ram_r_addr   (ram_r_addr),
        .ram_w_data   (ram_w_data),
        .ram_r_data   (ram_r_data),
        .cnt_clr      (cnt_clr),
        .wr_err_count (wr_err_count),
        .rd_err_count (rd_err_count)
    );

    always #5 clk = ~clk;

    function automatic int nb_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // Little-endian byte RAM attached to the controller's RAM port.
    logic [7:0] tb_mem [DEPTH] = '{default: 8'h00};
    int wen_total = 0;

    always_comb begin
        ram_r_data = '0;
        for (int i = 0; i < 4; i++)
            if (int'(ram_r_addr) + i < DEPTH)
                ram_r_data[8*i +: 8] = tb_mem[int'(ram_r_addr) + i];
    end

    always @(posedge clk) begin
        if (ram_w_en) begin
            for (int i = 0; i < nb_of(ram_select); i++)
                if (int'(ram_w_addr) + i < DEPTH)
                    tb_mem[int'(ram_w_addr) + i] <= ram_w_data[8*i +: 8];
            wen_total++;
        end
    end

    // Reference model: legal-access rules, shadow byte memory, saturating error counts.
    logic [7:0] ref_mem [DEPTH] = '{default: 8'h00};
    int m_wr = 0;
    int m_rd = 0;

    task automatic model_op(input logic we, input logic [1:0] sz, input logic [3:0] addr,
                            input logic [31:0] wdata, output logic exp_err, output logic [31:0] exp_data);
        int n;
        int a;
        n = nb_of(sz);
        a = int'(addr);
        exp_err  = (sz == 2'd3) || ((a % n) != 0) || (a + n > DEPTH);
        exp_data = '0;
        if (exp_err) begin
            if (we) m_wr = (m_wr < 255) ? m_wr + 1 : 255;
            else    m_rd = (m_rd < 255) ? m_rd + 1 : 255;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) exp_data[8*i +: 8] = ref_mem[a + i];
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // One full transaction; hold = cycles rsp_ready stays low once the response is up.
    task automatic do_op(input string tag, input logic we, input logic [1:0] sz, input logic [3:0] addr,
                         input logic [31:0] wdata, input int hold, input bit clr_exec,
                         output logic [31:0] o_data, output logic o_err);
        logic        exp_err;
        logic [31:0] exp_data;
        int cyc;
        int lat;
        int w0;
        o_data = '0;
        o_err  = 1'b0;
        model_op(we, sz, addr, wdata, exp_err, exp_data);
        if (clr_exec) begin
            m_wr = 0;
            m_rd = 0;
        end
        w0 = wen_total;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = (hold == 0);
        cyc = 0;
        while (!bus.req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.req_ready) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        cnt_clr = clr_exec;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            cnt_clr = 1'b0;
            lat++;
        end
        cnt_clr = 1'b0;
        check({tag, "_latency"}, lat, 2);
        if (!bus.rsp_valid) begin
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            return;
        end
        o_data = bus.rsp_data;
        o_err  = bus.rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_hold_data"}, bus.rsp_data, exp_data);
            check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
        bus.rsp_ready = 1'b0;
        check({tag, "_err"}, 32'(o_err), 32'(exp_err));
        check({tag, "_data"}, o_data, exp_data);
        check({tag, "_wen_pulses"}, wen_total - w0, (we && !exp_err) ? 1 : 0);
        check({tag, "_wr_cnt"}, 32'(wr_err_count), m_wr);
        check({tag, "_rd_cnt"}, 32'(rd_err_count), m_rd);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_wc;
        int          exp_rc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        logic [31:0] d;
        logic        e;
        int          w0;
        int          cyc;

        vecs[0]  = '{1'b1, 2'd2, 4'd4,  32'hDEADBEEF, 1'b0, 32'h0,        0, 0};
        vecs[1]  = '{1'b0, 2'd2, 4'd4,  32'h0,        1'b0, 32'hDEADBEEF, 0, 0};
        vecs[2]  = '{1'b1, 2'd1, 4'd3,  32'h1234,     1'b1, 32'h0,        1, 0};
        vecs[3]  = '{1'b0, 2'd2, 4'd2,  32'h0,        1'b1, 32'h0,        1, 1};
        vecs[4]  = '{1'b1, 2'd2, 4'd12, 32'h11223344, 1'b0, 32'h0,        1, 1};
        vecs[5]  = '{1'b0, 2'd2, 4'd12, 32'h0,        1'b0, 32'h11223344, 1, 1};
        vecs[6]  = '{1'b0, 2'd1, 4'd14, 32'h0,        1'b0, 32'h00001122, 1, 1};
        vecs[7]  = '{1'b0, 2'd2, 4'd14, 32'h0,        1'b1, 32'h0,        1, 2};
        vecs[8]  = '{1'b0, 2'd3, 4'd0,  32'h0,        1'b1, 32'h0,        1, 3};
        vecs[9]  = '{1'b1, 2'd0, 4'd8,  32'hFFFFFFA5, 1'b0, 32'h0,        1, 3};
        vecs[10] = '{1'b0, 2'd0, 4'd8,  32'h0,        1'b0, 32'h000000A5, 1, 3};
        vecs[11] = '{1'b0, 2'd1, 4'd5,  32'h0,        1'b1, 32'h0,        1, 4};
        vecs[12] = '{1'b0, 2'd0, 4'd15, 32'h0,        1'b0, 32'h00000011, 1, 4};
        vecs[13] = '{1'b1, 2'd1, 4'd4,  32'hFFFFCAFE, 1'b0, 32'h0,        1, 4};
        vecs[14] = '{1'b0, 2'd2, 4'd4,  32'h0,        1'b0, 32'hDEADCAFE, 1, 4};
        vecs[15] = '{1'b0, 2'd0, 4'd7,  32'h0,        1'b0, 32'h000000DE, 1, 4};
        vecs[16] = '{1'b1, 2'd2, 4'd13, 32'h01020304, 1'b1, 32'h0,        2, 4};
        vecs[17] = '{1'b1, 2'd0, 4'd15, 32'h00000077, 1'b0, 32'h0,        2, 4};
        vecs[18] = '{1'b0, 2'd0, 4'd15, 32'h0,        1'b0, 32'h00000077, 2, 4};
        vecs[19] = '{1'b1, 2'd3, 4'd0,  32'h0,        1'b1, 32'h0,        3, 4};

        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd0;
        bus.req_addr  = 4'd0;
        bus.req_wdata = 32'hFFFFFFFF;
        bus.rsp_ready = 1'b0;

        // Reset state, with a request already pending that must not be taken.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_ram_w_en", 32'(ram_w_en), 32'd0);
        check("rst_wr_cnt", 32'(wr_err_count), 32'd0);
        check("rst_rd_cnt", 32'(rd_err_count), 32'd0);
        check("rst_ram_select", 32'(ram_select), 32'd0);
        check("rst_ram_w_addr", 32'(ram_w_addr), 32'd0);
        check("rst_ram_r_addr", 32'(ram_r_addr), 32'd0);
        check("rst_ram_w_data", ram_w_data, 32'd0);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wdata,
                  0, 1'b0, d, e);
            check($sformatf("vec%0d_err_tab", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_data_tab", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_wr_cnt_tab", i), 32'(wr_err_count), vecs[i].exp_wc);
            check($sformatf("vec%0d_rd_cnt_tab", i), 32'(rd_err_count), vecs[i].exp_rc);
        end

        // Backpressure: byte read of 0xA5 held for 10 cycles.
        do_op("bp", 1'b0, 2'd0, 4'd8, 32'h0, 10, 1'b0, d, e);
        check("bp_data_const", d, 32'h000000A5);

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            do_op("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  $urandom, int'($urandom_range(0, 2)), 1'b0, d, e);
        end

        // Write error counter saturation, then clear colliding with an increment.
        for (int i = 0; i < 300; i++) begin
            do_op("mis", 1'b1, 2'd1, 4'(2 * $urandom_range(0, 7) + 1), $urandom, 0, 1'b0, d, e);
        end
        check("wr_cnt_sat", 32'(wr_err_count), 32'd255);
        do_op("clr", 1'b1, 2'd1, 4'd1, 32'h0, 0, 1'b1, d, e);
        check("clr_wins_wr", 32'(wr_err_count), 32'd0);
        check("clr_wins_rd", 32'(rd_err_count), 32'd0);
        do_op("after_clr", 1'b1, 2'd2, 4'd2, 32'h0, 0, 1'b0, d, e);
        check("after_clr_wr", 32'(wr_err_count), 32'd1);

        // Reset during EXEC of a legal write: no write, no response.
        w0 = wen_total;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 4'd0;
        bus.req_wdata = 32'h55667788;
        bus.rsp_ready = 1'b1;
        cyc = 0;
        while (!bus.req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rstx_accept", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstx_no_wen", 32'(ram_w_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstx_req_ready", 32'(bus.req_ready), 32'd1);
        check("rstx_no_rsp", 32'(bus.rsp_valid), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("rstx_still_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        check("rstx_wen_pulses", wen_total - w0, 32'd0);
        check("rstx_wr_cnt", 32'(wr_err_count), 32'd0);
        m_wr = 0;
        m_rd = 0;
        do_op("rstx_readback", 1'b0, 2'd2, 4'd0, 32'h0, 0, 1'b0, d, e);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
